adc128s022_spi_ctrl: RTL and testbench
======================================

Name: adc128s022_spi_ctrl

Overview:
SPI master for the on-board ADC128S022 8-channel 12-bit ADC. It continuously converts while enabled, applies the requested channel address, and deserializes each 16-bit frame. It presents the latest 12-bit sample, with its channel tag and a one-cycle valid strobe. It sits directly upstream of the 12-bit ADC-data PIO input port, whose in_port is driven by sample_data.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (25 at 50 MHz gives 1 MHz SCLK); legal range is 2 or more.

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enable  input  1  level; 1 = run back-to-back conversion frames
ch_sel  input  3  channel to address in the next frame
adc_dout  input  1  serial data from ADC (DOUT)
adc_sclk  output  1  SPI clock to ADC; idles high
adc_cs_n  output  1  ADC chip select, active low
adc_din  output  1  serial address to ADC (DIN)
sample_data  output  12  last converted sample, held until the next update
sample_ch  output  3  channel that sample_data belongs to
sample_valid  output  1  one-cycle pulse when sample_data/sample_ch update
busy  output  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk. reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values (all registered outputs):
  - adc_cs_n=1, adc_sclk=1, adc_din=0
  - sample_data=0, sample_ch=0, sample_valid=0, busy=0
  - state=IDLE, internal prev_ch=0
- Counters:
  - div_cnt runs 0..CLK_DIV-1.
  - bit_cnt runs 0..15.
  - A phase flag selects the low or high SCLK half.
- State machine, four states:
  - IDLE: cs_n=1, sclk=1. If enable=1, latch cur_ch<=ch_sel, drive cs_n=0, go to START.
  - START: cs_n=0, sclk=1 for CLK_DIV cycles (CS setup time). Then go to SHIFT with bit_cnt=0.
  - SHIFT: 16 SCLK cycles. Each cycle is a low half of CLK_DIV clks followed by a high half of CLK_DIV clks.
    - On entering each low half (falling SCLK), drive adc_din: bit_cnt 2,3,4 carry cur_ch[2],[1],[0]; all other bits are 0.
    - On the clk edge where sclk goes 0->1, shift adc_dout into shift_reg for bit_cnt 4..15 (MSB first). Bits 0..3 are leading zeros from the ADC and are ignored.
    - After the 16th high half, go to DONE.
  - DONE: cs_n=1, sclk=1 for CLK_DIV cycles (quiet time).
    - On entry, sample_data<=shift_reg, sample_ch<=prev_ch, prev_ch<=cur_ch, sample_valid=1 for exactly that one cycle.
    - Then go to START if enable=1 (re-latching ch_sel), else IDLE.
- Channel pipelining: the ADC converts the channel addressed in the previous frame. sample_ch is therefore the cur_ch of the prior frame. The first frame after reset is tagged ch0, the ADC power-on default.
- Frame period: (1+32+1)*CLK_DIV clk cycles. With CLK_DIV=25 this is 850 cycles, about 58.8 ksps.
- Boundary conditions:
  - ch_sel changes mid-frame: ignored until the next START.
  - enable deasserts mid-frame: the current frame completes with a normal sample_valid, then IDLE.
  - enable reasserts in DONE: it is honoured at DONE exit.
  - reset_n low at any point, including mid-SHIFT: on the next clk edge all outputs take reset values, the partial frame is discarded, and no sample_valid is issued.
- adc_dout is sampled directly. SCLK is generated locally, so no synchronizer is needed, and the sample point is a full half-period after the ADC's falling-edge update.
- sample_data/sample_ch change only in the sample_valid cycle, so a downstream registered reader always sees a coherent pair.

Test Plan:
- Reset: hold reset_n=0 for 5 clks with enable=1 -> cs_n=1, sclk=1, din=0, sample_data=0x000, sample_ch=0, valid=0, busy=0.
- Single frame, CLK_DIV=25, ch_sel=5, ADC model returns 0xA5C -> exactly 16 SCLK rising edges; DIN bits 2..4 = 1,0,1, all others 0; sample_data=0xA5C, sample_ch=0; valid high 1 cycle, 825 clks after cs_n falls; busy returns to 0 after 850 cycles.
- Channel pipeline: enable=1 with ch_sel=3 for frame 1, ch_sel=6 for frame 2, model echoes (addressed ch)<<8 -> frame 1 gives sample_ch=0, frame 2 gives sample_ch=3 with data=0x300; consecutive valids 850 clks apart.
- enable dropped at bit_cnt=7 -> frame finishes, one valid pulse, then cs_n=1 and busy=0 with no further SCLK edges.
- reset_n=0 for 1 clk at bit_cnt=10 -> next clk cs_n=1, sclk=1, sample_data stays 0, no valid pulse; the next frame after enable runs normally.
- Extremes with CLK_DIV=2: model returns 0x000, then 0xFFF -> both captured exactly; frame period 68 clks; SCLK high/low each 2 clks.

Source files
------------

// File: rtl/adc128s022_spi_ctrl.sv
// SPI master for the ADC128S022: back-to-back 16-bit frames while enabled,
// presenting each 12-bit result with its channel tag and a one-cycle valid.
module adc128s022_spi_ctrl #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [2:0]  ch_sel,
    input  logic        adc_dout,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_din,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

    localparam int            DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          phase, phase_nxt;
    logic [2:0]    cur_ch, prev_ch;
    logic [11:0]   shift_reg;
    logic          div_done, sclk_rise;
    logic          cs_n_nxt, sclk_nxt, din_nxt, valid_nxt;

    assign div_done  = (div_cnt == DIV_LAST);
    // phase 0 is the SCLK-low half; its last clk is where SCLK rises.
    assign sclk_rise = (state == SHIFT) && !phase && div_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            phase   <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_done ? '0 : div_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        phase_nxt   = phase;
        unique case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                if (enable) state_nxt = START;
            end
            START: begin
                if (div_done) begin
                    state_nxt   = SHIFT;
                    phase_nxt   = 1'b0;
                    bit_cnt_nxt = 4'd0;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    phase_nxt = ~phase;
                    if (phase) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (div_done) state_nxt = enable ? START : IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they align with it.
    always_comb begin
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b1;
        din_nxt   = 1'b0;
        valid_nxt = (state == SHIFT) && (state_nxt == DONE);
        case (state_nxt)
            START: cs_n_nxt = 1'b0;
            SHIFT: begin
                cs_n_nxt = 1'b0;
                sclk_nxt = phase_nxt;
                case (bit_cnt_nxt)
                    4'd2:    din_nxt = cur_ch[2];
                    4'd3:    din_nxt = cur_ch[1];
                    4'd4:    din_nxt = cur_ch[0];
                    default: din_nxt = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            adc_din      <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            cur_ch       <= '0;
            prev_ch      <= '0;
            shift_reg    <= '0;
        end else begin
            adc_cs_n     <= cs_n_nxt;
            adc_sclk     <= sclk_nxt;
            adc_din      <= din_nxt;
            sample_valid <= valid_nxt;
            busy         <= (state_nxt != IDLE);
            if (state_nxt == START && state != START) cur_ch <= ch_sel;
            if (sclk_rise && bit_cnt >= 4'd4) shift_reg <= {shift_reg[10:0], adc_dout};
            // The ADC converts the channel addressed one frame earlier.
            if (valid_nxt) begin
                sample_data <= shift_reg;
                sample_ch   <= prev_ch;
                prev_ch     <= cur_ch;
            end
        end
    end

endmodule

// File: tb/tb_adc128s022_spi_ctrl.sv
// Bench for adc128s022_spi_ctrl: two instances (CLK_DIV 25 and 2), an ADC
// behavioural model, a frame-position reference model and a per-cycle compare.
module tb_adc128s022_spi_ctrl;

  localparam int DIV0 = 25;
  localparam int DIV1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_a [2];
  logic        enable_a  [2];
  logic [2:0]  ch_sel_a  [2];
  logic        adc_dout_a[2];
  logic        sclk_a    [2];
  logic        cs_n_a    [2];
  logic        din_a     [2];
  logic [11:0] data_a    [2];
  logic [2:0]  ch_a      [2];
  logic        valid_a   [2];
  logic        busy_a    [2];

  adc128s022_spi_ctrl #(.CLK_DIV(DIV0)) u_dut25 (
    .clk(clk), .reset_n(reset_n_a[0]), .enable(enable_a[0]), .ch_sel(ch_sel_a[0]),
    .adc_dout(adc_dout_a[0]), .adc_sclk(sclk_a[0]), .adc_cs_n(cs_n_a[0]), .adc_din(din_a[0]),
    .sample_data(data_a[0]), .sample_ch(ch_a[0]), .sample_valid(valid_a[0]), .busy(busy_a[0])
  );

  adc128s022_spi_ctrl #(.CLK_DIV(DIV1)) u_dut2 (
    .clk(clk), .reset_n(reset_n_a[1]), .enable(enable_a[1]), .ch_sel(ch_sel_a[1]),
    .adc_dout(adc_dout_a[1]), .adc_sclk(sclk_a[1]), .adc_cs_n(cs_n_a[1]), .adc_din(din_a[1]),
    .sample_data(data_a[1]), .sample_ch(ch_a[1]), .sample_valid(valid_a[1]), .busy(busy_a[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // per-instance conversion result table of the ADC, one entry per channel
  logic [11:0] chan_tab[2][8];

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", name, g, cyc, got, want);
    end
  endtask

  // ---------------- reference model: position within the frame -------------
  bit          m_active[2];
  int          m_t[2];
  logic [2:0]  m_cur[2];
  logic [2:0]  m_prev[2];
  logic [11:0] m_pend[2];
  logic [11:0] m_data[2];
  logic [2:0]  m_ch[2];
  bit          m_valid[2];
  bit          m_rst_seen[2];
  int          md;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      md = div_of(g);
      m_valid[g] = 1'b0;
      m_rst_seen[g] = !reset_n_a[g];
      if (!reset_n_a[g]) begin
        m_active[g] = 1'b0; m_t[g] = 0; m_cur[g] = '0; m_prev[g] = '0;
        m_data[g] = '0; m_ch[g] = '0;
      end else if (!m_active[g]) begin
        if (enable_a[g]) begin
          m_active[g] = 1'b1; m_t[g] = 0; m_cur[g] = ch_sel_a[g];
          m_pend[g] = chan_tab[g][m_prev[g]];
        end
      end else if (m_t[g] == 34 * md - 1) begin
        if (enable_a[g]) begin
          m_t[g] = 0; m_cur[g] = ch_sel_a[g];
          m_pend[g] = chan_tab[g][m_prev[g]];
        end else begin
          m_active[g] = 1'b0;
        end
      end else begin
        m_t[g] = m_t[g] + 1;
        if (m_t[g] == 33 * md) begin
          m_valid[g] = 1'b1; m_data[g] = m_pend[g]; m_ch[g] = m_prev[g]; m_prev[g] = m_cur[g];
        end
      end
    end
  end

  // ---------------- compare: every cycle after reset ------------------------
  int cd, ct, cu, ck;
  logic e_cs, e_sclk, e_din;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int g = 0; g < 2; g++) begin
        cd = div_of(g); ct = m_t[g];
        e_cs = 1'b1; e_sclk = 1'b1; e_din = 1'b0;
        if (m_active[g] && ct < 33 * cd) begin
          e_cs = 1'b0;
          if (ct >= cd) begin
            cu = ct - cd;
            e_sclk = ((cu / cd) % 2 == 1);
            ck = cu / (2 * cd);
            if (ck >= 2 && ck <= 4) e_din = m_cur[g][4 - ck];
          end
        end
        check("cs_n", g, 32'(cs_n_a[g]), 32'(e_cs));
        check("sclk", g, 32'(sclk_a[g]), 32'(e_sclk));
        check("din", g, 32'(din_a[g]), 32'(e_din));
        check("busy", g, 32'(busy_a[g]), 32'(m_active[g]));
        check("valid", g, 32'(valid_a[g]), 32'(m_valid[g]));
        check("data", g, 32'(data_a[g]), 32'(m_data[g]));
        check("ch", g, 32'(ch_a[g]), 32'(m_ch[g]));
      end
    end
  end

  // ---------------- ADC model + event monitor -------------------------------
  logic        prev_cs[2]   = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b1, 1'b1};
  logic        prev_busy[2] = '{1'b0, 1'b0};
  int          falls[2], rises[2], last_rises[2];
  logic [2:0]  acc[2];
  logic [2:0]  adc_addr[2];
  logic [11:0] out_val[2];
  int          fall_cnt[2], fall_cyc[2], bfall_cnt[2], bfall_cyc[2];
  int          v_cnt[2], v_last_cyc[2], v_prev_cyc[2];
  logic [11:0] v_last_data[2];
  logic [2:0]  v_last_ch[2];

  initial begin
    adc_dout_a[0] = 1'b0;
    adc_dout_a[1] = 1'b0;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (m_rst_seen[g]) begin
        adc_addr[g] = '0; falls[g] = 0; rises[g] = 0;
      end
      if (prev_cs[g] === 1'b1 && cs_n_a[g] === 1'b0) begin
        out_val[g] = chan_tab[g][adc_addr[g]];
        falls[g] = 0; rises[g] = 0; acc[g] = '0; adc_dout_a[g] = 1'b0;
        fall_cnt[g]++; fall_cyc[g] = cyc;
      end
      if (cs_n_a[g] === 1'b0 && prev_sclk[g] === 1'b1 && sclk_a[g] === 1'b0) begin
        adc_dout_a[g] = (falls[g] >= 4) ? out_val[g][15 - falls[g]] : 1'b0;
        falls[g]++;
      end
      if (cs_n_a[g] === 1'b0 && prev_sclk[g] === 1'b0 && sclk_a[g] === 1'b1) begin
        if (rises[g] >= 2 && rises[g] <= 4) acc[g][4 - rises[g]] = din_a[g];
        rises[g]++;
      end
      if (prev_cs[g] === 1'b0 && cs_n_a[g] === 1'b1) begin
        last_rises[g] = rises[g];
        if (rises[g] == 16) adc_addr[g] = acc[g];
      end
      if (prev_busy[g] === 1'b1 && busy_a[g] === 1'b0) begin
        bfall_cnt[g]++; bfall_cyc[g] = cyc;
      end
      if (valid_a[g] === 1'b1) begin
        v_cnt[g]++; v_prev_cyc[g] = v_last_cyc[g]; v_last_cyc[g] = cyc;
        v_last_data[g] = data_a[g]; v_last_ch[g] = ch_a[g];
      end
      prev_cs[g] = cs_n_a[g]; prev_sclk[g] = sclk_a[g]; prev_busy[g] = busy_a[g];
    end
  end

  // ---------------- driver tasks ---------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int get_cnt(input int g, input int which);
    case (which)
      0:       return fall_cnt[g];
      1:       return v_cnt[g];
      default: return bfall_cnt[g];
    endcase
  endfunction

  task automatic wait_cnt(input int g, input int which, input int base, input int budget, input string name);
    int n;
    n = 0;
    while (get_cnt(g, which) <= base && n < budget) begin
      tick(1);
      n++;
    end
    check(name, g, 32'(get_cnt(g, which) > base), 32'd1);
  endtask

  task automatic fill_tab(input int g, input logic [11:0] v);
    for (int c = 0; c < 8; c++) chan_tab[g][c] = v;
  endtask

  task automatic pulse_reset(input int g, input int n);
    reset_n_a[g] = 1'b0;
    tick(n);
    reset_n_a[g] = 1'b1;
  endtask

  task automatic rand_reset(input int g);
    reset_n_a[g] = 1'b0;
    tick(1);
    for (int c = 0; c < 8; c++) chan_tab[g][c] = 12'($urandom_range(0, 4095));
    tick(1);
    reset_n_a[g] = 1'b1;
  endtask

  // ---------------- main sequence --------------------------------------------
  int bf, bv, bb;

  initial begin
    for (int g = 0; g < 2; g++) begin
      reset_n_a[g] = 1'b0; enable_a[g] = 1'b1; ch_sel_a[g] = '0;
      fill_tab(g, 12'h000);
    end
    tick(1);
    cmp_en = 1'b1;
    tick(4);
    for (int g = 0; g < 2; g++) begin
      check("rst_cs_n", g, 32'(cs_n_a[g]), 32'd1);
      check("rst_sclk", g, 32'(sclk_a[g]), 32'd1);
      check("rst_din", g, 32'(din_a[g]), 32'd0);
      check("rst_data", g, 32'(data_a[g]), 32'h000);
      check("rst_busy", g, 32'(busy_a[g]), 32'd0);
      enable_a[g] = 1'b0;
    end
    reset_n_a[0] = 1'b1; reset_n_a[1] = 1'b1;
    tick(3);

    // single frame, ch_sel=5, ADC returns 0xA5C
    fill_tab(0, 12'hA5C);
    bf = fall_cnt[0]; bv = v_cnt[0]; bb = bfall_cnt[0];
    enable_a[0] = 1'b1; ch_sel_a[0] = 3'd5;
    wait_cnt(0, 0, bf, 50, "cs_fall_timeout");
    enable_a[0] = 1'b0;
    wait_cnt(0, 1, bv, 1200, "valid_timeout");
    check("single_data", 0, 32'(v_last_data[0]), 32'hA5C);
    check("single_ch", 0, 32'(v_last_ch[0]), 32'd0);
    check("valid_latency", 0, 32'(v_last_cyc[0] - fall_cyc[0]), 32'd825);
    wait_cnt(0, 2, bb, 200, "busy_timeout");
    check("frame_len", 0, 32'(bfall_cyc[0] - fall_cyc[0]), 32'd850);
    check("sclk_rises", 0, 32'(last_rises[0]), 32'd16);
    check("din_addr", 0, 32'(adc_addr[0]), 32'd5);
    check("one_valid", 0, 32'(v_cnt[0] - bv), 32'd1);

    // channel pipeline, ADC echoes addressed channel << 8
    pulse_reset(0, 2);
    for (int c = 0; c < 8; c++) chan_tab[0][c] = 12'(c << 8);
    bf = fall_cnt[0]; bv = v_cnt[0];
    enable_a[0] = 1'b1; ch_sel_a[0] = 3'd3;
    wait_cnt(0, 0, bf, 50, "cs_fall_timeout");
    tick(100);
    ch_sel_a[0] = 3'd6;
    wait_cnt(0, 1, bv, 1200, "valid_timeout");
    check("pipe1_ch", 0, 32'(v_last_ch[0]), 32'd0);
    check("pipe1_data", 0, 32'(v_last_data[0]), 32'h000);
    bv = v_cnt[0];
    wait_cnt(0, 1, bv, 1200, "valid_timeout");
    check("pipe2_ch", 0, 32'(v_last_ch[0]), 32'd3);
    check("pipe2_data", 0, 32'(v_last_data[0]), 32'h300);
    check("pipe_period", 0, 32'(v_last_cyc[0] - v_prev_cyc[0]), 32'd850);

    // enable dropped around bit 7 of frame 3
    bf = fall_cnt[0]; bv = v_cnt[0]; bb = bfall_cnt[0];
    wait_cnt(0, 0, bf, 100, "cs_fall_timeout");
    tick(DIV0 + 7 * 2 * DIV0 + 10);
    enable_a[0] = 1'b0;
    wait_cnt(0, 1, bv, 1200, "valid_timeout");
    check("drop_ch", 0, 32'(v_last_ch[0]), 32'd6);
    check("drop_data", 0, 32'(v_last_data[0]), 32'h600);
    wait_cnt(0, 2, bb, 200, "busy_timeout");
    bf = fall_cnt[0]; bv = v_cnt[0];
    tick(200);
    check("drop_no_frame", 0, 32'(fall_cnt[0] - bf), 32'd0);
    check("drop_no_valid", 0, 32'(v_cnt[0] - bv), 32'd0);
    check("drop_busy", 0, 32'(busy_a[0]), 32'd0);

    // one-clock reset around bit 10
    bf = fall_cnt[0];
    enable_a[0] = 1'b1; ch_sel_a[0] = 3'd4;
    wait_cnt(0, 0, bf, 50, "cs_fall_timeout");
    tick(DIV0 + 10 * 2 * DIV0 + 10);
    bv = v_cnt[0];
    reset_n_a[0] = 1'b0;
    tick(1);
    reset_n_a[0] = 1'b1; enable_a[0] = 1'b0;
    check("abort_cs_n", 0, 32'(cs_n_a[0]), 32'd1);
    check("abort_sclk", 0, 32'(sclk_a[0]), 32'd1);
    check("abort_data", 0, 32'(data_a[0]), 32'h000);
    tick(100);
    check("abort_no_valid", 0, 32'(v_cnt[0] - bv), 32'd0);
    chan_tab[0][0] = 12'h123;
    bf = fall_cnt[0]; bv = v_cnt[0];
    enable_a[0] = 1'b1; ch_sel_a[0] = 3'd2;
    wait_cnt(0, 0, bf, 50, "cs_fall_timeout");
    enable_a[0] = 1'b0;
    wait_cnt(0, 1, bv, 1200, "valid_timeout");
    check("after_abort_data", 0, 32'(v_last_data[0]), 32'h123);
    check("after_abort_ch", 0, 32'(v_last_ch[0]), 32'd0);

    // CLK_DIV=2 extremes: 0x000 then 0xFFF
    pulse_reset(1, 2);
    fill_tab(1, 12'h000);
    bf = fall_cnt[1]; bv = v_cnt[1];
    enable_a[1] = 1'b1; ch_sel_a[1] = 3'd1;
    wait_cnt(1, 0, bf, 20, "cs_fall_timeout");
    tick(1);
    fill_tab(1, 12'hFFF);
    wait_cnt(1, 1, bv, 200, "valid_timeout");
    check("min_data", 1, 32'(v_last_data[1]), 32'h000);
    check("fast_latency", 1, 32'(v_last_cyc[1] - fall_cyc[1]), 32'd66);
    bv = v_cnt[1];
    wait_cnt(1, 1, bv, 200, "valid_timeout");
    enable_a[1] = 1'b0;
    check("max_data", 1, 32'(v_last_data[1]), 32'hFFF);
    check("max_ch", 1, 32'(v_last_ch[1]), 32'd1);
    check("fast_period", 1, 32'(v_last_cyc[1] - v_prev_cyc[1]), 32'd68);
    tick(80);

    // randomized run on the fast instance
    rand_reset(1);
    bv = v_cnt[1];
    enable_a[1] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ch_sel_a[1] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) enable_a[1] = ~enable_a[1];
      if ($urandom_range(0, 399) == 0) rand_reset(1);
      else tick(1);
    end
    check("random_saw_valids", 1, 32'(v_cnt[1] > bv + 10), 32'd1);
    enable_a[1] = 1'b0;
    tick(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
